// File: rtl/param_stack.sv
// param_stack: parametrised LIFO operand stack used by the recursive
// Fibonacci datapath. It supports flush, status flags, overflow/underflow
// pulses with a sticky error bit, and a same-cycle push+pop that replaces
// the top entry.
// Optional peak-occupancy tracking is enabled by defining the macro
// PARAM_STACK_HIGH_WATER_EN. Without it, high_water is tied to zero.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   high_water
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             overflow_r;
  logic             underflow_r;
  logic             err_r;
  logic             ovf_next_s;
  logic             unf_next_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    top_idx_s;
  logic             empty_s;
  logic             full_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == DEPTH_C);
  assign top_idx_s = AW'(count_r - {{(CW-1){1'b0}}, 1'b1});

  // Decide the write, the next occupancy and any rejection for this cycle
  always_comb begin
    count_next_s = count_r;
    ovf_next_s   = 1'b0;
    unf_next_s   = 1'b0;
    wr_en_s      = 1'b0;
    wr_idx_s     = {AW{1'b0}};
    if (push && pop) begin
      if (!empty_s) begin
        // Replace the top entry in place; occupancy is unchanged
        wr_en_s  = 1'b1;
        wr_idx_s = top_idx_s;
      end else begin
        // Nothing to pop: the push still lands, the pop is rejected
        wr_en_s      = 1'b1;
        wr_idx_s     = {AW{1'b0}};
        count_next_s = {{(CW-1){1'b0}}, 1'b1};
        unf_next_s   = 1'b1;
      end
    end else if (push) begin
      if (!full_s) begin
        wr_en_s      = 1'b1;
        wr_idx_s     = AW'(count_r);
        count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        ovf_next_s = 1'b1;
      end
    end else if (pop) begin
      if (!empty_s) begin
        count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        unf_next_s = 1'b1;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Occupancy, rejection pulses and the sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      err_r       <= 1'b0;
    end else if (clear) begin
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      overflow_r  <= ovf_next_s;
      underflow_r <= unf_next_s;
      err_r       <= err_r | ovf_next_s | unf_next_s;
    end
  end

  // Storage write; contents are not reset, only logically discarded
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst && !clear) begin
      mem_r[wr_idx_s] <= din;
    end
  end

`ifdef PARAM_STACK_HIGH_WATER_EN
  logic [CW-1:0] high_water_r;

  // Track the deepest occupancy reached since the last reset or flush
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      high_water_r <= {CW{1'b0}};
    end else if (count_next_s > high_water_r) begin
      high_water_r <= count_next_s;
    end else begin
      high_water_r <= high_water_r;
    end
  end

  assign high_water = high_water_r;
`else
  assign high_water = {CW{1'b0}};
`endif

  assign dout      = empty_s ? {WIDTH{1'b0}} : mem_r[top_idx_s];
  assign count     = count_r;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign err       = err_r;

endmodule
